universal_switch_box: RTL and testbench
=======================================

# universal_switch_box

Unidirectional routing switch box for the FPGA interconnect fabric, sitting at each channel intersection. It connects W-track north/east/south/west input channels to the matching W-track output channels. Each output track is driven through a 3:1 mux whose select is a 2-bit field of a static configuration word. The data path is combinational. A clocked error flag reports illegal (value 3) select fields.

## Interface

Parameters:
- W, default 7: tracks per side; any W ≥ 1, odd or even.

Ports:
- clk, input, 1: clock; used only for cfg_err.
- rst_n, input, 1: asynchronous, active-low reset.
- north_in, input, W: north input tracks.
- east_in, input, W: east input tracks.
- south_in, input, W: south input tracks.
- west_in, input, W: west input tracks.
- north_out, output, W: north output tracks.
- east_out, output, W: east output tracks.
- south_out, output, W: south output tracks.
- west_out, output, W: west output tracks.
- c, input, 8*W: configuration word, made of 2-bit select fields.
- cfg_err, output, 1: registered flag; high when any select field in use equals 3.

## Operation

Tracks are handled in pairs. For k = 0 .. floor(W/2)−1:
- a = 2k, b = 2k+1, base = 16k.
- Select field f occupies bits c[base+2f+1 : base+2f].
- The three entries per field are the source for select 0 / 1 / 2.

Field assignments per pair:
- f0: north_out[a] ← east_in[a] / south_in[a] / west_in[b]
- f1: east_out[b] ← south_in[a] / west_in[b] / north_in[b]
- f2: south_out[b] ← west_in[b] / north_in[b] / east_in[a]
- f3: west_out[a] ← north_in[b] / east_in[a] / south_in[a]
- f4: north_out[b] ← east_in[b] / south_in[b] / west_in[a]
- f5: east_out[a] ← south_in[b] / west_in[a] / north_in[a]
- f6: south_out[a] ← west_in[a] / north_in[a] / east_in[b]
- f7: west_out[b] ← north_in[a] / east_in[b] / south_in[b]

Odd W, last track t = W−1, base = 8t. Four fields, with no twist:
- f0: north_out[t] ← east_in[t] / south_in[t] / west_in[t]
- f1: east_out[t] ← south_in[t] / west_in[t] / north_in[t]
- f2: south_out[t] ← west_in[t] / north_in[t] / east_in[t]
- f3: west_out[t] ← north_in[t] / east_in[t] / south_in[t]

Coverage and width:
- Every bit of c is used exactly once: 8 bits per track.
- The generic rule: each output selects among the other three sides in clockwise order.

Illegal select:
- A select value of 3 drives that output bit to 0.

Reset gating:
- While rst_n = 0, all four output buses are forced to 0, combinationally and asynchronously.

## Timing

Data path:
- Outputs are purely combinational from north_in/east_in/south_in/west_in, c and rst_n.
- No clock latency: any input or c change propagates within the same cycle.

cfg_err:
- Rising-edge register.
- Next value = OR over all fields of (field == 2'b11).
- Asynchronously cleared to 0 while rst_n = 0.
- First valid update is at the first clk rising edge after rst_n deasserts.
- Falls at the first edge after all fields become legal.

Reset values:
- All outputs read 0 during reset, cfg_err included.

Reset deassertion:
- Outputs immediately reflect the current configuration.
- cfg_err updates at the next rising edge.

## Test plan

All cases use W=7 and rst_n=1 unless noted.
- **All-zero config:** c = 0, east_in = 7'h55, south_in = 7'b0000001, north_in = 7'b0000010 → north_out = 7'h55, east_out = 7'b0000010 (pair swap), west_out = 7'b0000001 (pair swap), south_out = west_in; cfg_err = 0.
- **All fields = 1:** c = 56'h55555555555555, random inputs → north_out = south_in, east_out = west_in, south_out = north_in, west_out = east_in; cfg_err = 0.
- **All fields = 2:** c = 56'hAAAAAAAAAAAAAA, west_in = 7'b0000001, east_in = 7'b1000001 → north_out = 7'b0000010, south_out = 7'b1000010, east_out = north_in, west_out = south_in.
- **Illegal select:** c[1:0] = 3, all other fields = 0, east_in = 7'h7F → north_out[0] = 0 and north_out[6:1] = 1; cfg_err = 1 after the next rising edge, back to 0 one edge after c[1:0] is restored to 0.
- **Random sweep:** 100 cycles of random inputs and random c with every field in 0..2 → every output bit matches the mapping table; zero mismatches.
- **Reset mid-operation:** assert rst_n = 0 between clock edges while cfg_err = 1 and outputs are non-zero → all outputs and cfg_err go to 0 immediately; after release, outputs track c immediately.

Source files
------------

// File: rtl/universal_switch_box.sv
// universal_switch_box: static-config unidirectional switch box with registered illegal-select flag
module universal_switch_box #(
  parameter int W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   north_in,
  input  logic [W-1:0]   east_in,
  input  logic [W-1:0]   south_in,
  input  logic [W-1:0]   west_in,
  output logic [W-1:0]   north_out,
  output logic [W-1:0]   east_out,
  output logic [W-1:0]   south_out,
  output logic [W-1:0]   west_out,
  input  logic [8*W-1:0] c,
  output logic           cfg_err
);
  logic [W-1:0] n_mux, e_mux, s_mux, w_mux;
  logic err_next;
  function automatic logic pick(input logic [1:0] s, input logic x0, input logic x1, input logic x2);
    return s == 2'd0 ? x0 : s == 2'd1 ? x1 : s == 2'd2 ? x2 : 1'b0;
  endfunction
  for (genvar k = 0; k < W / 2; k++) begin : g_pair
    localparam int A = 2 * k;
    localparam int B = 2 * k + 1;
    localparam int BS = 16 * k;
    assign n_mux[A] = pick(c[BS+1:BS],   east_in[A],  south_in[A], west_in[B]);
    assign e_mux[B] = pick(c[BS+3:BS+2], south_in[A], west_in[B],  north_in[B]);
    assign s_mux[B] = pick(c[BS+5:BS+4], west_in[B],  north_in[B], east_in[A]);
    assign w_mux[A] = pick(c[BS+7:BS+6], north_in[B], east_in[A],  south_in[A]);
    assign n_mux[B] = pick(c[BS+9:BS+8],   east_in[B],  south_in[B], west_in[A]);
    assign e_mux[A] = pick(c[BS+11:BS+10], south_in[B], west_in[A],  north_in[A]);
    assign s_mux[A] = pick(c[BS+13:BS+12], west_in[A],  north_in[A], east_in[B]);
    assign w_mux[B] = pick(c[BS+15:BS+14], north_in[A], east_in[B],  south_in[B]);
  end
  if (W % 2 == 1) begin : g_last
    localparam int T = W - 1;
    localparam int BS = 8 * T;
    assign n_mux[T] = pick(c[BS+1:BS],   east_in[T],  south_in[T], west_in[T]);
    assign e_mux[T] = pick(c[BS+3:BS+2], south_in[T], west_in[T],  north_in[T]);
    assign s_mux[T] = pick(c[BS+5:BS+4], west_in[T],  north_in[T], east_in[T]);
    assign w_mux[T] = pick(c[BS+7:BS+6], north_in[T], east_in[T],  south_in[T]);
  end
  assign north_out = {W{rst_n}} & n_mux;
  assign east_out  = {W{rst_n}} & e_mux;
  assign south_out = {W{rst_n}} & s_mux;
  assign west_out  = {W{rst_n}} & w_mux;
  // every 2-bit slice of c is a field, so any slice equal to 3 is illegal
  always_comb begin
    err_next = 1'b0;
    for (int i = 0; i < 4 * W; i++) err_next = err_next | (c[2*i] & c[2*i+1]);
  end
  // register the illegal-select flag, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else cfg_err <= err_next;
  end
endmodule

// File: tb/tb_universal_switch_box.sv
// tb_universal_switch_box: scoreboard bench, stimulus pushes expectations, monitor checks at negedge
module tb_universal_switch_box;
  localparam int W = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] north_in = '0, east_in = '0, south_in = '0, west_in = '0;
  logic [W-1:0] north_out, east_out, south_out, west_out;
  logic [8*W-1:0] c = '0;
  logic cfg_err;
  int total = 0;
  int bad = 0;
  typedef struct {
    string name;
    logic [W-1:0] n, e, s, w;
    logic err;
  } exp_t;
  exp_t q[$];

  universal_switch_box #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
    .north_out(north_out), .east_out(east_out), .south_out(south_out), .west_out(west_out),
    .c(c), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // independent reference: output side d picks side (d+1+sel)%4; pair tracks twist by group
  function automatic logic [4*W-1:0] model(input logic [8*W-1:0] cc, input logic [W-1:0] n, e, s, w);
    logic [W-1:0] src [4];
    logic [W-1:0] o [4];
    src[0] = n; src[1] = e; src[2] = s; src[3] = w;
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < W; t++) begin
        int base, side, st, g, k;
        logic [1:0] sel;
        k = t / 2;
        if (W % 2 == 1 && t == W - 1) begin
          base = 8 * t + 2 * d;
          sel = cc[base +: 2];
          side = (d + 1 + int'(sel)) % 4;
          st = t;
        end else begin
          g = (d == 0 || d == 3) ? (t % 2) : 1 - (t % 2);
          base = 16 * k + 2 * (4 * g + d);
          sel = cc[base +: 2];
          side = (d + 1 + int'(sel)) % 4;
          st = 2 * k + (((side == 0 || side == 3) ? 1 : 0) ^ g);
        end
        o[d][t] = (sel == 2'd3) ? 1'b0 : src[side][st];
      end
    end
    return {o[3], o[2], o[1], o[0]};
  endfunction

  task automatic step(input string nm, input logic r, input logic [8*W-1:0] cc,
                      input logic [W-1:0] n, e, s, w,
                      input logic [W-1:0] xn, xe, xs, xw, input logic xerr);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r; c = cc; north_in = n; east_in = e; south_in = s; west_in = w;
    x.name = nm; x.n = xn; x.e = xe; x.s = xs; x.w = xw; x.err = xerr;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: pop one expectation per cycle and compare mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk({x.name, ".north"}, north_out, x.n);
      chk({x.name, ".east"}, east_out, x.e);
      chk({x.name, ".south"}, south_out, x.s);
      chk({x.name, ".west"}, west_out, x.w);
      chk({x.name, ".cfg_err"}, {{(W-1){1'b0}}, cfg_err}, {{(W-1){1'b0}}, x.err});
    end
  end

  initial begin
    logic [8*W-1:0] rc;
    logic [W-1:0] rn, re, rs, rw;
    logic [4*W-1:0] m;
    step("reset", 1'b0, 56'h55555555555555, 7'h12, 7'h34, 7'h56, 7'h78, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
    step("zero",  1'b1, 56'h0, 7'h02, 7'h55, 7'h01, 7'h33, 7'h55, 7'h02, 7'h33, 7'h01, 1'b0);
    step("ones",  1'b1, 56'h55555555555555, 7'h12, 7'h34, 7'h56, 7'h78, 7'h56, 7'h78, 7'h12, 7'h34, 1'b0);
    step("twos",  1'b1, 56'hAAAAAAAAAAAAAA, 7'h2A, 7'h41, 7'h4C, 7'h01, 7'h02, 7'h2A, 7'h42, 7'h4C, 1'b0);
    step("ill0",  1'b1, 56'h3, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h7E, 7'h00, 7'h00, 7'h00, 1'b0);
    step("ill1",  1'b1, 56'h3, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h7E, 7'h00, 7'h00, 7'h00, 1'b1);
    step("fix0",  1'b1, 56'h0, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h00, 1'b1);
    step("fix1",  1'b1, 56'h0, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h00, 1'b0);
    step("pre0",  1'b1, 56'h3, 7'h2A, 7'h7F, 7'h4C, 7'h33, 7'h7E, 7'h4C, 7'h33, 7'h15, 1'b0);
    step("pre1",  1'b1, 56'h3, 7'h2A, 7'h7F, 7'h4C, 7'h33, 7'h7E, 7'h4C, 7'h33, 7'h15, 1'b1);
    step("rst",   1'b0, 56'h3, 7'h2A, 7'h7F, 7'h4C, 7'h33, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
    step("rel0",  1'b1, 56'h3, 7'h2A, 7'h7F, 7'h4C, 7'h33, 7'h7E, 7'h4C, 7'h33, 7'h15, 1'b0);
    step("rel1",  1'b1, 56'h3, 7'h2A, 7'h7F, 7'h4C, 7'h33, 7'h7E, 7'h4C, 7'h33, 7'h15, 1'b1);
    step("clr",   1'b1, 56'h0, 7'h2A, 7'h7F, 7'h4C, 7'h33, 7'h7F, 7'h4C, 7'h33, 7'h15, 1'b1);
    for (int i = 0; i < 100; i++) begin
      for (int f = 0; f < 4 * W; f++) rc[2*f +: 2] = 2'($urandom_range(0, 2));
      rn = W'($urandom); re = W'($urandom); rs = W'($urandom); rw = W'($urandom);
      m = model(rc, rn, re, rs, rw);
      step("rand", 1'b1, rc, rn, re, rs, rw, m[W-1:0], m[2*W-1:W], m[3*W-1:2*W], m[4*W-1:3*W], 1'b0);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
